// File: rtl/disp_marquee_if.sv
// rtl/disp_marquee_if.sv - bus between taxi controller and LED marquee selector
interface disp_marquee_if #(
  parameter int NUM_DIG   = 4,
  parameter int NUM_CH    = 3,
  parameter int LABEL_LEN = 5
);
  localparam int CHW = $clog2(NUM_CH + 1);

  logic                          tick;
  logic [1:0]                    state;
  logic [CHW-1:0]                sel;
  logic [NUM_CH*NUM_DIG*8-1:0]   values;
  logic [NUM_CH*LABEL_LEN*7-1:0] labels;
  logic [NUM_DIG*8-1:0]          digit;
  logic [CHW-1:0]                mq_ch;
  logic                          mq_done;

  modport master (
    output tick, state, sel, values, labels,
    input  digit, mq_ch, mq_done
  );

  modport slave (
    input  tick, state, sel, values, labels,
    output digit, mq_ch, mq_done
  );
endinterface

// File: rtl/disp_marquee.sv
// rtl/disp_marquee.sv - parametrised LED digit selector with idle scrolling marquee
module disp_marquee #(
  parameter int         NUM_DIG   = 4,
  parameter int         NUM_CH    = 3,
  parameter int         LABEL_LEN = 5,
  parameter int         BLINKS    = 2,
  parameter int         ON_TICKS  = 3,
  parameter int         OFF_TICKS = 3,
  parameter bit         LOOP      = 1'b1,
  parameter logic [1:0] IDLE_CODE = 2'b00
) (
  input  logic           clk,
  input  logic           rst_n,
  disp_marquee_if.slave  bus
);
  localparam int CHW    = $clog2(NUM_CH + 1);
  localparam int DW     = NUM_DIG * 8;
  localparam int PER    = ON_TICKS + OFF_TICKS;
  localparam int SCROLL = LABEL_LEN + NUM_DIG;
  localparam int CH_LEN = SCROLL + 1 + BLINKS * PER;
  localparam int PCW    = $clog2(CH_LEN + 1);
  localparam int BPW    = $clog2(PER + 1);

  if (NUM_DIG < 1 || NUM_CH < 1 || LABEL_LEN < 1 || ON_TICKS < 1 || OFF_TICKS < 1) begin : g_param_check
    $error("disp_marquee: NUM_DIG, NUM_CH, LABEL_LEN, ON_TICKS and OFF_TICKS must be >= 1");
  end

  logic [NUM_CH*DW-1:0]   lock_q, lock_d;
  logic [PCW-1:0]         pc_q, pc_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic [BPW-1:0]         bp_q, bp_d;
  logic                   stop_q, stop_d;
  logic                   prev_idle_q;
  logic [DW-1:0]          digit_q, digit_d;
  logic                   done_q, done_d;

  logic                   idle, entry;
  logic [LABEL_LEN*7-1:0] lab_row;
  logic [DW-1:0]          lock_row, man_row, frame_d;

  assign idle  = (bus.state == IDLE_CODE);
  assign entry = idle && !prev_idle_q;

  // Pick the rows of the current channel / manual selection and render the marquee frame
  always_comb begin
    lab_row  = '1;
    lock_row = '1;
    man_row  = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CHW'(c)) begin
        lab_row  = bus.labels[c*LABEL_LEN*7 +: LABEL_LEN*7];
        lock_row = lock_q[c*DW +: DW];
      end
      if (bus.sel == CHW'(c + 1)) begin
        man_row = bus.values[c*DW +: DW];
      end
    end
    frame_d = '1;
    if (pc_q >= PCW'(1) && pc_q <= PCW'(SCROLL - 1)) begin
      // Window of NUM_DIG characters sliding right-to-left across the label
      for (int i = 0; i < NUM_DIG; i++) begin
        for (int j = 0; j < LABEL_LEN; j++) begin
          if (int'(pc_q) - NUM_DIG + i == j) begin
            frame_d[(NUM_DIG-1-i)*8 +: 8] = {lab_row[j*7 +: 7], 1'b1};
          end
        end
      end
    end else if (pc_q > PCW'(SCROLL) && bp_q < BPW'(ON_TICKS)) begin
      frame_d = lock_row;
    end
  end

  // Next-state for snapshot, phase/channel counters and the displayed frame
  always_comb begin
    lock_d  = lock_q;
    pc_d    = pc_q;
    ch_d    = ch_q;
    bp_d    = bp_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    digit_d = frame_d;
    if (!idle) begin
      pc_d    = '0;
      ch_d    = '0;
      bp_d    = '0;
      stop_d  = 1'b0;
      digit_d = man_row;
    end else if (entry) begin
      lock_d  = bus.values;
      pc_d    = '0;
      ch_d    = '0;
      bp_d    = '0;
      stop_d  = 1'b0;
      digit_d = '1;
    end else if (stop_q) begin
      digit_d = '1;
    end else if (bus.tick) begin
      if (pc_q == PCW'(CH_LEN - 1)) begin
        pc_d = '0;
        bp_d = '0;
        if (ch_q == CHW'(NUM_CH - 1)) begin
          ch_d   = '0;
          done_d = 1'b1;
          stop_d = ~LOOP;
        end else begin
          ch_d = ch_q + CHW'(1);
        end
      end else begin
        pc_d = pc_q + PCW'(1);
        // bp tracks the position inside the current on/off blink period
        if (pc_q == PCW'(SCROLL)) begin
          bp_d = '0;
        end else if (pc_q > PCW'(SCROLL)) begin
          bp_d = (bp_q == BPW'(PER - 1)) ? '0 : bp_q + BPW'(1);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= '1;
      pc_q        <= '0;
      ch_q        <= '0;
      bp_q        <= '0;
      stop_q      <= 1'b0;
      prev_idle_q <= 1'b0;
      digit_q     <= '1;
      done_q      <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      pc_q        <= pc_d;
      ch_q        <= ch_d;
      bp_q        <= bp_d;
      stop_q      <= stop_d;
      prev_idle_q <= idle;
      digit_q     <= digit_d;
      done_q      <= done_d;
    end
  end

  assign bus.digit   = digit_q;
  assign bus.mq_ch   = ch_q;
  assign bus.mq_done = done_q;
endmodule

// File: tb/tb_disp_marquee.sv
// tb/tb_disp_marquee.sv - randomized self-checking bench for disp_marquee
module tb_disp_marquee;
  localparam int ND = 4, LL = 5, CH_LEN = 22, PER = 6, ON = 3;
  localparam logic [6:0] LP_ = 7'h0C, LR = 7'h2F, LI = 7'h79, LC = 7'h46, LE = 7'h06;
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         tick;
  logic [1:0]   state;
  logic [1:0]   sel;
  logic [95:0]  vals;
  logic [104:0] labs;

  disp_marquee_if #(.NUM_DIG(4), .NUM_CH(3), .LABEL_LEN(5)) if0 ();
  disp_marquee_if #(.NUM_DIG(4), .NUM_CH(2), .LABEL_LEN(5)) if1 ();

  assign if0.tick = tick;  assign if0.state = state;  assign if0.sel = sel;
  assign if0.values = vals;  assign if0.labels = labs;
  assign if1.tick = tick;  assign if1.state = state;  assign if1.sel = sel;
  assign if1.values = vals[63:0];  assign if1.labels = labs[69:0];

  disp_marquee u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  disp_marquee #(.NUM_CH(2), .LOOP(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: ticks counted since IDLE entry, everything else derived arithmetically
  int          nch [2] = '{3, 2};
  bit          lp  [2] = '{1'b1, 1'b0};
  int          m_n [2];
  bit          m_prev [2];
  logic [31:0] m_lock [2][3];
  logic [31:0] e_dig [2];
  logic [31:0] e_ch [2];
  logic [31:0] e_done [2];

  function automatic logic [31:0] frame(input int pc, input logic [31:0] lock, input int ch);
    logic [31:0] f = BLANK;
    if (pc >= 1 && pc <= LL + ND - 1) begin
      for (int i = 0; i < ND; i++) begin
        int idx = pc - ND + i;
        if (idx >= 0 && idx < LL) f[(ND-1-i)*8 +: 8] = {labs[(ch*LL+idx)*7 +: 7], 1'b1};
      end
    end else if (pc >= LL + ND + 1) begin
      if ((pc - LL - ND - 1) % PER < ON) f = lock;
    end
    return f;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int total = nch[k] * CH_LEN;
      int s = int'(sel);
      bit stopped;
      e_done[k] = 0;
      if (state != 2'b00) begin
        e_dig[k] = (s >= 1 && s <= nch[k]) ? vals[(s-1)*32 +: 32] : BLANK;
        m_n[k] = 0;
      end else if (!m_prev[k]) begin
        for (int c = 0; c < nch[k]; c++) m_lock[k][c] = vals[c*32 +: 32];
        m_n[k] = 0;
        e_dig[k] = BLANK;
      end else begin
        int ch = (m_n[k] / CH_LEN) % nch[k];
        stopped = !lp[k] && (m_n[k] >= total);
        e_dig[k] = stopped ? BLANK : frame(m_n[k] % CH_LEN, m_lock[k][ch], ch);
        if (tick && !stopped) begin
          m_n[k]++;
          if (m_n[k] % total == 0) e_done[k] = 1;
        end
      end
      e_ch[k] = (m_n[k] / CH_LEN) % nch[k];
      m_prev[k] = (state == 2'b00);
    end
  endtask

  task automatic compare_all();
    chk("u0_digit", if0.digit, e_dig[0]);
    chk("u0_mq_ch", 32'(if0.mq_ch), e_ch[0]);
    chk("u0_mq_done", 32'(if0.mq_done), e_done[0]);
    chk("u1_digit", if1.digit, e_dig[1]);
    chk("u1_mq_ch", 32'(if1.mq_ch), e_ch[1]);
    chk("u1_mq_done", 32'(if1.mq_done), e_done[1]);
  endtask

  task automatic cycle(input bit tk, input logic [1:0] st, input logic [1:0] sl);
    tick = tk; state = st; sel = sl;
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  int   tk_n;
  logic d0, d1;

  // one tick cycle, then a quiet cycle so the new phase reaches the digit register
  task automatic show();
    cycle(1'b1, 2'b00, 2'd0);
    tk_n++;
    d0 = if0.mq_done;
    d1 = if1.mq_done;
    cycle(1'b0, 2'b00, 2'd0);
  endtask

  logic [31:0] snap;

  initial begin
    tick = 0; state = 2'b01; sel = 0;
    vals = {$urandom, 32'h039F_250D, $urandom};
    labs = 105'({$urandom, $urandom, $urandom, $urandom});
    labs[34:0] = {LE, LC, LI, LR, LP_};
    for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_prev[k] = 0; end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_digit0", if0.digit, BLANK);
    chk("rst_ch0", 32'(if0.mq_ch), 0);
    chk("rst_done0", 32'(if0.mq_done), 0);
    chk("rst_digit1", if1.digit, BLANK);
    rst_n = 1'b1;

    cycle(1'b0, 2'b01, 2'd2);
    chk("man_sel2", if0.digit, 32'h039F_250D);
    cycle(1'b0, 2'b01, 2'd0);
    chk("man_sel0", if0.digit, BLANK);
    cycle(1'b1, 2'b01, 2'd3);
    chk("man_sel3_nch2", if1.digit, BLANK);

    snap = vals[31:0];
    cycle(1'b0, 2'b00, 2'd0);
    chk("entry_blank", if0.digit, BLANK);
    vals = {$urandom, $urandom, $urandom};
    tk_n = 0;
    while (tk_n < 66) begin
      show();
      case (tk_n)
        1: chk("scroll_t1", if0.digit, {24'hFFFFFF, LP_, 1'b1});
        4: chk("scroll_t4", if0.digit, {LP_, 1'b1, LR, 1'b1, LI, 1'b1, LC, 1'b1});
        8: chk("scroll_t8", if0.digit, {LE, 1'b1, 24'hFFFFFF});
        9: chk("gap_t9", if0.digit, BLANK);
        10, 11, 12, 16, 17, 18: chk("blink_on", if0.digit, snap);
        13, 14, 15, 19, 20, 21: chk("blink_off", if0.digit, BLANK);
        22: begin chk("next_ch", 32'(if0.mq_ch), 1); chk("next_blank", if0.digit, BLANK); end
        44: chk("stop_done", 32'(d1), 1);
        66: begin
          chk("wrap_done", 32'(d0), 1);
          chk("wrap_pulse", 32'(if0.mq_done), 0);
          chk("wrap_ch", 32'(if0.mq_ch), 0);
        end
        default: ;
      endcase
      if (tk_n > 44) chk("stop_blank", if1.digit, BLANK);
    end
    repeat (20) begin
      show();
      chk("stop_hold", if1.digit, BLANK);
    end

    // leave IDLE on a tick mid-scroll, then re-enter on a tick
    repeat (3) show();
    cycle(1'b1, 2'b01, 2'd2);
    chk("exit_on_tick", if0.digit, vals[63:32]);
    chk("exit_ch", 32'(if0.mq_ch), 0);
    cycle(1'b0, 2'b01, 2'd2);
    snap = vals[31:0];
    cycle(1'b1, 2'b00, 2'd2);
    chk("reenter_blank", if0.digit, BLANK);
    vals = {$urandom, $urandom, $urandom};
    tk_n = 0;
    while (tk_n < 10) begin
      show();
      if (tk_n == 1) chk("reenter_pc0", if0.digit, {24'hFFFFFF, LP_, 1'b1});
    end
    chk("reenter_snap", if0.digit, snap);

    // randomized traffic; IDLE stretches long enough to cross channel and pass boundaries
    for (int c = 0; c < 3000; c++) begin
      bit tk;
      logic [1:0] st, sl;
      tk = ($urandom_range(0, 1) == 1);
      st = state;
      sl = 2'($urandom_range(0, 3));
      if (state == 2'b00) begin
        if ($urandom_range(0, 399) == 0) st = 2'($urandom_range(1, 3));
      end else if ($urandom_range(0, 19) == 0) begin
        st = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) vals = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 499) == 0) labs = 105'({$urandom, $urandom, $urandom, $urandom});
      cycle(tk, st, sl);
    end

    // asynchronous reset while channel 1 is blinking its locked value
    cycle(1'b0, 2'b01, 2'd0);
    cycle(1'b0, 2'b00, 2'd0);
    tk_n = 0;
    while (tk_n < 33) show();
    chk("pre_rst_ch", 32'(if0.mq_ch), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_digit0", if0.digit, BLANK);
    chk("arst_ch0", 32'(if0.mq_ch), 0);
    chk("arst_done0", 32'(if0.mq_done), 0);
    chk("arst_digit1", if1.digit, BLANK);
    chk("arst_ch1", 32'(if1.mq_ch), 0);
    for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_prev[k] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) show();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
